// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline-boundary register carrying a control bundle and a data bundle
// across a valid/ready handshake, with flush and bubble masking of control.
// SKID=1 adds a second entry so ready_o comes straight from a flop.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   valid_i  : upstream beat valid
//   ready_o  : stage can accept a beat
//   ctrl_i   : upstream control bundle
//   data_i   : upstream data bundle
//   flush_i  : kill all held and incoming beats this cycle
//   valid_o  : downstream beat valid
//   ready_i  : downstream accepts
//   ctrl_o   : control to next stage (CTRL_RST while no beat is valid)
//   data_o   : data to next stage (held, never cleared by flush or bubble)
//   occ_o    : number of entries held (0..2, max 1 when SKID=0)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned        CTRL_W   = 8,
    parameter int unsigned        DATA_W   = 111,
    parameter int unsigned        SKID     = 1,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    // Occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e              occ_q,    occ_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              ready_q,  ready_d;
    logic              in_fire;
    logic              out_fire;

    assign valid_o = (occ_q != OCC_EMPTY);
    // Skid variant: ready is a flop; single entry: classic pass-through ready.
    assign ready_o = (SKID != 0) ? ready_q : (!valid_o || ready_i);
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    // Bubbles always present CTRL_RST so no write enable leaks downstream.
    assign ctrl_o = valid_o ? m_ctrl_q : CTRL_RST;
    assign data_o = m_data_q;
    assign occ_o  = occ_q;

    // Next-state: occupancy transitions and entry loads.
    always_comb begin
        occ_d    = occ_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        if (flush_i) begin
            // Data is left in place; only occupancy is dropped.
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        m_ctrl_d = ctrl_i;
                        m_data_d = data_i;
                        occ_d    = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        m_ctrl_d = ctrl_i;
                        m_data_d = data_i;
                    end else if (in_fire) begin
                        // Only reachable with SKID=1: park the beat behind M.
                        s_ctrl_d = ctrl_i;
                        s_data_d = data_i;
                        occ_d    = OCC_TWO;
                    end else if (out_fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_fire) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        occ_d    = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end

        ready_d = (occ_d != OCC_TWO);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q    <= OCC_EMPTY;
            ready_q  <= 1'b1;
            m_ctrl_q <= CTRL_RST;
            m_data_q <= '0;
            s_ctrl_q <= CTRL_RST;
            s_data_q <= '0;
        end else begin
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and compares
// both against a FIFO-based reference model, plus directed spot checks.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 111;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_i, valid_i, flush_i, ready_i;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;

    logic          r1, v1, r0, v0;
    logic [CW-1:0] c1, c0;
    logic [DW-1:0] d1, d0;
    logic [1:0]    o1, o0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CTRL_RST(8'h00)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r1),
        .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i),
        .valid_o(v1), .ready_i(ready_i), .ctrl_o(c1), .data_o(d1), .occ_o(o1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CTRL_RST(8'h00)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r0),
        .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i),
        .valid_o(v0), .ready_i(ready_i), .ctrl_o(c0), .data_o(d0), .occ_o(o0)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: index 0 = single entry, index 1 = two-entry skid.
    beat_t         fifo [2][2];
    int            cnt  [2];
    logic [DW-1:0] last_d [2];
    bit            rdy1;
    int            cap  [2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(input int k);
        if (k == 1) return rdy1;
        return (cnt[0] == 0) || ready_i;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit inf [2];
        bit outf [2];
        for (int k = 0; k < 2; k++) begin
            inf[k]  = valid_i && model_ready(k);
            outf[k] = (cnt[k] > 0) && ready_i;
        end
        for (int k = 0; k < 2; k++) begin
            if (rst_i) begin
                cnt[k]    = 0;
                last_d[k] = '0;
            end else if (flush_i) begin
                cnt[k] = 0;
            end else begin
                if (outf[k]) begin
                    fifo[k][0] = fifo[k][1];
                    cnt[k]--;
                end
                if (inf[k] && cnt[k] < cap[k]) begin
                    fifo[k][cnt[k]] = '{c: ctrl_i, d: data_i};
                    cnt[k]++;
                end
                if (cnt[k] > 0) last_d[k] = fifo[k][0].d;
            end
        end
        rdy1 = rst_i ? 1'b1 : (cnt[1] < 2);
    endtask

    task automatic post_chk(input int k, input logic v, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic [1:0] o);
        string s;
        s = (k == 1) ? "skid1" : "skid0";
        chk({s, "_valid"}, 128'(v), 128'(cnt[k] > 0));
        chk({s, "_ctrl"},  128'(c), 128'((cnt[k] > 0) ? fifo[k][0].c : 8'h00));
        chk({s, "_data"},  128'(d), 128'((cnt[k] > 0) ? fifo[k][0].d : last_d[k]));
        chk({s, "_occ"},   128'(o), 128'(cnt[k]));
        chk({s, "_valid_vs_occ"}, 128'(v), 128'(o != 2'd0));
        chk({s, "_occ_le2"}, 128'(o <= 2'd2), 128'(1));
    endtask

    // One clock: drive inputs, check handshake before the edge, check state after.
    task automatic cyc(input logic rst, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic f, input logic r);
        rst_i   = rst;
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
        flush_i = f;
        ready_i = r;
        #1;
        if (chk_en) begin
            chk("skid1_ready", 128'(r1), 128'(model_ready(1)));
            chk("skid0_ready", 128'(r0), 128'(model_ready(0)));
            chk("skid1_no_in_when_full", 128'(valid_i && r1 && (o1 == 2'd2)), 128'(0));
        end
        model_edge();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        post_chk(1, v1, c1, d1, o1);
        post_chk(0, v0, c0, d0, o0);
    endtask

    initial begin
        cap[0] = 1; cap[1] = 2;
        cnt[0] = 0; cnt[1] = 0;
        last_d[0] = '0; last_d[1] = '0;
        rdy1 = 1'b1;

        // Reset held for two cycles with valid_i asserted.
        cyc(1, 1, 8'hAA, 111'h123, 0, 1);
        cyc(1, 1, 8'hAA, 111'h123, 0, 1);
        chk("t1_valid", 128'(v1), 128'(0));
        chk("t1_ctrl",  128'(c1), 128'(8'h00));
        chk("t1_occ",   128'(o1), 128'(0));
        chk("t1_ready", 128'(r1), 128'(1));
        chk("t1_data",  128'(d1), 128'(0));

        // Back-to-back streaming.
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, CW'(i), DW'(i), 0, 1);
            chk("t2_ctrl", 128'(c1), 128'(i));
            chk("t2_occ",  128'(o1), 128'(1));
            chk("t6_skid0_ctrl", 128'(c0), 128'(i));
        end
        cyc(0, 0, 8'h00, '0, 0, 1);

        // Back-pressure: A, B, then C held upstream.
        cyc(0, 1, 8'h11, DW'(17), 0, 0);
        cyc(0, 1, 8'h22, DW'(34), 0, 0);
        chk("t3_ready_low", 128'(r1), 128'(0));
        cyc(0, 1, 8'h33, DW'(51), 0, 0);
        cyc(0, 1, 8'h33, DW'(51), 0, 0);
        chk("t3_hold_ctrl", 128'(c1), 128'(8'h11));
        chk("t3_hold_occ",  128'(o1), 128'(2));
        chk("t6_skid0_ready_low", 128'(r0), 128'(0));
        chk("t6_skid0_hold", 128'(c0), 128'(8'h11));
        cyc(0, 1, 8'h33, DW'(51), 0, 1);
        chk("t3_out_b", 128'(c1), 128'(8'h22));
        cyc(0, 1, 8'h33, DW'(51), 0, 1);
        chk("t3_out_c", 128'(c1), 128'(8'h33));
        cyc(0, 0, 8'h00, '0, 0, 1);
        chk("t3_drained", 128'(v1), 128'(0));

        // Flush with two entries held and a beat offered.
        cyc(0, 1, 8'h55, DW'(85), 0, 0);
        cyc(0, 1, 8'h66, DW'(102), 0, 0);
        cyc(0, 1, 8'h44, DW'(68), 1, 0);
        chk("t4_valid", 128'(v1), 128'(0));
        chk("t4_ctrl",  128'(c1), 128'(8'h00));
        chk("t4_occ",   128'(o1), 128'(0));
        cyc(0, 0, 8'h00, '0, 0, 1);
        chk("t4_no_0x44", 128'(v1), 128'(0));

        // Bubble masking keeps data but zeroes control.
        cyc(0, 1, 8'hFF, DW'(12'hABC), 0, 1);
        chk("t5_loaded", 128'(c1), 128'(8'hFF));
        cyc(0, 0, 8'h00, '0, 0, 1);
        cyc(0, 0, 8'h00, '0, 0, 1);
        chk("t5_ctrl_masked", 128'(c1), 128'(8'h00));
        chk("t5_data_held",   128'(d1), 128'(12'hABC));

        // Randomized traffic, including flush and mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                CW'($urandom), DW'({$urandom, $urandom, $urandom, $urandom}),
                ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
